// File: rtl/polaris_pkg.sv
// Shared definitions for the polaris fetch pipeline: fetch FSM states and
// the default reset fetch address.
package polaris_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no bus cycle, waiting for a free queue slot
        ST_BUSY  = 2'd1,   // bus cycle open at f_adr_o
        ST_DRAIN = 2'd2,   // bus cycle open, its data will be thrown away
        ST_HALT  = 2'd3    // stopped after an error until redirected
    } fq_state_e;

    localparam logic [63:0] RESET_PC_DEF = 64'hFFFF_FFFF_FFFF_FF00;

endpackage

// File: rtl/stage_fq_fifo.sv
// Circular prefetch buffer: DEPTH entries of W bits, wrapping pointers,
// an occupancy count one bit wider than the pointers, and a flush.
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 63,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [W-1:0]  i_data,
    output logic [W-1:0]  o_head,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;

    // Pointer/count bookkeeping and storage; flush wins over push/pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= r_wp + 1'b1;
            end
            if (i_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rp];
    assign o_count = r_count;

endmodule

// File: rtl/stage_fq.sv
// Instruction fetch queue: Wishbone classic fetch master feeding a small
// prefetch queue, with redirect (flush + restart) and error halt.
module stage_fq
    import polaris_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    output logic            f_cyc_o,
    input  logic            f_ack_i,
    input  logic            f_err_i,
    output logic [XLEN-1:2] f_adr_o,
    input  logic [31:0]     f_dat_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:2] redirect_pc_i,
    output logic            i_valid_o,
    input  logic            i_ready_i,
    output logic [31:0]     i_dat_o,
    output logic [XLEN-1:2] i_pc_o,
    output logic            i_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 32 + XLEN - 2 + 1;
    localparam logic [XLEN-1:0] RST_BYTE = RESET_PC[XLEN-1:0];
    localparam logic [XLEN-1:2] RST_WORD = RST_BYTE[XLEN-1:2];
    localparam logic [XLEN-1:2] ADR_ONE  = 1;
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);

    fq_state_e       r_state;
    logic            r_cyc;
    logic [XLEN-1:2] r_adr;
    logic [XLEN-1:2] r_tgt;

    logic            w_term;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_cnt_pop;
    logic [CW-1:0]   w_cnt_nxt;
    logic [EW-1:0]   w_head;

    // A termination only counts while a cycle is open; pushes only happen in
    // BUSY, and a redirect voids both the pop and the push of that clock.
    assign w_term    = r_cyc & (f_ack_i | f_err_i);
    assign w_push    = (r_state == ST_BUSY) & w_term & ~redirect_i;
    assign w_pop     = i_valid_o & i_ready_i & ~redirect_i;
    assign w_cnt_pop = w_count - CW'(w_pop);
    assign w_cnt_nxt = w_cnt_pop + CW'(w_push);

    fq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (reset_ni),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .i_data  ({f_dat_i, r_adr, f_err_i}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Fetch FSM; cycle and address are registered so f_adr_o stays put for
    // the whole bus cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= ST_IDLE;
            r_cyc   <= 1'b0;
            r_adr   <= RST_WORD;
            r_tgt   <= RST_WORD;
        end else if (redirect_i) begin
            if ((r_state == ST_BUSY || r_state == ST_DRAIN) && !w_term) begin
                // Cycle still outstanding: let it finish, remember target.
                r_state <= ST_DRAIN;
                r_tgt   <= redirect_pc_i;
            end else begin
                r_state <= ST_BUSY;
                r_cyc   <= 1'b1;
                r_adr   <= redirect_pc_i;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cnt_pop < DEPTH_C) begin
                        r_state <= ST_BUSY;
                        r_cyc   <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_term) begin
                        if (f_err_i) begin
                            r_state <= ST_HALT;
                            r_cyc   <= 1'b0;
                        end else begin
                            r_adr <= r_adr + ADR_ONE;
                            if (w_cnt_nxt >= DEPTH_C) begin
                                r_state <= ST_IDLE;
                                r_cyc   <= 1'b0;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    // Queue was flushed on entry, so a slot is always free.
                    if (w_term) begin
                        r_state <= ST_BUSY;
                        r_adr   <= r_tgt;
                    end
                end
                ST_HALT: ;
                default: begin
                    r_state <= ST_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase
        end
    end

    assign f_cyc_o   = r_cyc;
    assign f_adr_o   = r_adr;
    assign i_valid_o = (w_count != '0);
    assign i_dat_o   = w_head[EW-1 -: 32];
    assign i_pc_o    = w_head[XLEN-2:1];
    assign i_err_o   = i_valid_o & w_head[0];

endmodule
